// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the QR eigenvalue engine front-end: sizes, FSM states,
// Q6.10 constants and the column-major element index used by every stage.
package matrix_loader_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 4;
    localparam int ELEMS  = N * N;
    localparam int CNT_W  = 4;
    localparam int MAT_W  = DATA_W * ELEMS;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic signed [DATA_W-1:0] ONE           = 16'sd1024;
    localparam logic signed [DATA_W-1:0] RANGE_MAX_DEF = 16'sd8192;

    // Column-major packing: element (row, col) lives at slot 4*col + row.
    function automatic logic [CNT_W-1:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
        elem_idx = {col, row};
    endfunction

endpackage

// File: rtl/matrix_loader_buf.sv
// Sixteen-slot collect buffer with write index and sticky out-of-range flag.
// The flag logic exists only when MATRIX_LOADER_RANGE_CHK_EN is defined.
module matrix_loader_buf
    import matrix_loader_pkg::*;
#(
    parameter logic signed [DATA_W-1:0] RANGE_MAX = RANGE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_first,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_clr,
    output logic [MAT_W-1:0]  buf_data,
    output logic              partial,
    output logic              last_word,
    output logic              buf_flag,
    output logic              word_flag
);

    logic [DATA_W-1:0] slot_r [ELEMS];
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  wr_idx_s;

    // Write index, buffer flattening and end-of-matrix detection.
    always_comb begin
        buf_data = {MAT_W{1'b0}};
        if (wr_first) begin
            wr_idx_s = {CNT_W{1'b0}};
        end else begin
            wr_idx_s = cnt_r;
        end
        for (int k = 0; k < ELEMS; k++) begin
            buf_data[DATA_W*k +: DATA_W] = slot_r[k];
        end
        partial   = (cnt_r != {CNT_W{1'b0}});
        last_word = wr_en && !wr_first && (cnt_r == 4'd15);
    end

    // Slot storage and write index; a marker word restarts the matrix at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            for (int k = 0; k < ELEMS; k++) begin
                slot_r[k] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            slot_r[wr_idx_s] <= wr_data;
            if (wr_first) begin
                cnt_r <= 4'd1;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

`ifdef MATRIX_LOADER_RANGE_CHK_EN
    logic signed [DATA_W:0] ext_s;
    logic signed [DATA_W:0] mag_s;
    logic                   oor_s;
    logic                   flag_r;

    // 17-bit magnitude so that -32768 is representable and gets flagged.
    always_comb begin
        ext_s = {wr_data[DATA_W-1], wr_data};
        if (ext_s[DATA_W]) begin
            mag_s = -ext_s;
        end else begin
            mag_s = ext_s;
        end
        oor_s = (mag_s > $signed({1'b0, RANGE_MAX}));
    end

    // Sticky flag follows the matrix being collected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_r <= 1'b0;
        end else if (flag_clr) begin
            flag_r <= 1'b0;
        end else if (wr_en && wr_first) begin
            flag_r <= oor_s;
        end else if (wr_en) begin
            flag_r <= flag_r | oor_s;
        end
    end

    assign buf_flag  = flag_r;
    assign word_flag = flag_r | (wr_en & oor_s);
`else
    logic unused_s;
    assign unused_s  = ^{flag_clr, RANGE_MAX};
    assign buf_flag  = 1'b0;
    assign word_flag = 1'b0;
`endif

endmodule

// File: rtl/matrix_loader.sv
// Double-buffered 4x4 Q6.10 matrix loader: 16-word stream in, 256-bit matrix out.
// Optional range check enabled by defining MATRIX_LOADER_RANGE_CHK_EN.
module matrix_loader #(
    parameter int                 DATA_W    = 16,
    parameter int                 N         = 4,
    parameter logic signed [15:0] RANGE_MAX = 16'sd8192
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_first,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W*N*N-1:0]      m_matrix,
    output logic                       m_range_err,
    output logic                       resync_err
);

    import matrix_loader_pkg::*;

    state_t           state_r;
    state_t           state_next_s;
    logic             s_ready_r;
    logic             m_valid_r;
    logic             m_range_err_r;
    logic             resync_err_r;
    logic [MAT_W-1:0] m_matrix_r;

    logic             accept_s;
    logic             hs_s;
    logic             slot_free_s;
    logic             copy_fill_s;
    logic             copy_pend_s;
    logic             copy_s;
    logic             copy_flag_s;
    logic             m_valid_next_s;
    logic             resync_s;
    logic [MAT_W-1:0] copy_data_s;

    logic [MAT_W-1:0] buf_data_s;
    logic             partial_s;
    logic             last_word_s;
    logic             buf_flag_s;
    logic             word_flag_s;

    assign accept_s    = s_valid && s_ready_r;
    assign hs_s        = m_valid_r && m_ready;
    assign slot_free_s = !m_valid_r || m_ready;
    assign resync_s    = accept_s && s_first && partial_s;

    matrix_loader_buf #(
        .RANGE_MAX (RANGE_MAX)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept_s),
        .wr_first  (s_first),
        .wr_data   (s_data),
        .flag_clr  (copy_s),
        .buf_data  (buf_data_s),
        .partial   (partial_s),
        .last_word (last_word_s),
        .buf_flag  (buf_flag_s),
        .word_flag (word_flag_s)
    );

    // Next-state logic: a full matrix either goes straight out or waits in PEND.
    always_comb begin
        state_next_s = state_r;
        copy_fill_s  = 1'b0;
        copy_pend_s  = 1'b0;
        case (state_r)
            FILL: begin
                if (last_word_s) begin
                    if (slot_free_s) begin
                        copy_fill_s = 1'b1;
                    end else begin
                        state_next_s = PEND;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            PEND: begin
                if (hs_s) begin
                    copy_pend_s  = 1'b1;
                    state_next_s = FILL;
                end else begin
                    state_next_s = PEND;
                end
            end
            default: begin
                state_next_s = FILL;
            end
        endcase
    end

    // Output-slot source: word 15 bypasses the buffer when copied on its own accept edge.
    always_comb begin
        copy_s = copy_fill_s || copy_pend_s;
        if (copy_fill_s) begin
            copy_data_s = {s_data, buf_data_s[MAT_W-DATA_W-1:0]};
            copy_flag_s = word_flag_s;
        end else begin
            copy_data_s = buf_data_s;
            copy_flag_s = buf_flag_s;
        end
        if (copy_s) begin
            m_valid_next_s = 1'b1;
        end else if (hs_s) begin
            m_valid_next_s = 1'b0;
        end else begin
            m_valid_next_s = m_valid_r;
        end
    end

    // State, handshake outputs and the held matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FILL;
            s_ready_r     <= 1'b0;
            m_valid_r     <= 1'b0;
            m_matrix_r    <= {MAT_W{1'b0}};
            m_range_err_r <= 1'b0;
            resync_err_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            s_ready_r    <= (state_next_s == FILL);
            m_valid_r    <= m_valid_next_s;
            resync_err_r <= resync_s;
            if (copy_s) begin
                m_matrix_r    <= copy_data_s;
                m_range_err_r <= copy_flag_s;
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign m_valid     = m_valid_r;
    assign m_matrix    = m_matrix_r;
    assign m_range_err = m_range_err_r;
    assign resync_err  = resync_err_r;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader with a word-level reference model.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_first = 1'b0;
    logic [15:0]  s_data = 16'h0000;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [255:0] m_matrix;
    logic         m_range_err;
    logic         resync_err;

    matrix_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_first     (s_first),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_matrix    (m_matrix),
        .m_range_err (m_range_err),
        .resync_err  (resync_err)
    );

    always #5 clk = ~clk;

`ifdef MATRIX_LOADER_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;
    int acc_cnt = 0;
    int cyc_cnt = 0;
    int resync_cnt = 0;
    int exp_resync = 0;
    bit rand_ready = 1'b0;

    logic [255:0] got_q[$];
    logic         got_flag_q[$];
    logic [255:0] exp_q[$];
    logic         exp_flag_q[$];

    // reference model state: words of the matrix being collected
    logic [15:0] cur[16];
    int          mcnt = 0;
    bit          cur_flag = 1'b0;

    function automatic bit over(input logic [15:0] d);
        int v;
        v = $signed(d);
        return (v > 8192) || (v < -8192);
    endfunction

    task automatic model_word(input logic [15:0] d, input bit f);
        if (f) begin
            if (mcnt != 0) exp_resync++;
            mcnt = 0;
            cur_flag = 1'b0;
        end
        cur[mcnt] = d;
        if (CHK && over(d)) cur_flag = 1'b1;
        mcnt++;
        if (mcnt == 16) begin
            logic [255:0] m;
            m = '0;
            for (int k = 0; k < 16; k++) m[16*k +: 16] = cur[k];
            exp_q.push_back(m);
            exp_flag_q.push_back(cur_flag);
            mcnt = 0;
            cur_flag = 1'b0;
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        cur_flag = 1'b0;
        exp_q.delete();
        exp_flag_q.delete();
        got_q.delete();
        got_flag_q.delete();
    endtask

    // One clock: record what the upcoming edge accepts/consumes, then advance.
    task automatic cycle();
        if (s_valid && s_ready) acc_cnt++;
        if (m_valid && m_ready) begin
            got_q.push_back(m_matrix);
            got_flag_q.push_back(m_range_err);
        end
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (resync_err) resync_cnt++;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [15:0] d, input bit f);
        int n;
        n = 0;
        model_word(d, f);
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        while (!s_ready && n < 200) begin
            cycle();
            n++;
        end
        if (!s_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
        end
        cycle();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_rand_matrix(input bit gaps);
        for (int k = 0; k < 16; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) cycle();
            send_word(16'($urandom_range(0, 65535)), (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared += 5;
        if (s_ready !== 1'b0)      begin mismatched++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        if (m_valid !== 1'b0)      begin mismatched++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        if (m_matrix !== 256'd0)   begin mismatched++; $display("FAIL reset_m_matrix: got %h required 0", m_matrix); end
        if (m_range_err !== 1'b0)  begin mismatched++; $display("FAIL reset_range_err: got %b required 0", m_range_err); end
        if (resync_err !== 1'b0)   begin mismatched++; $display("FAIL reset_resync_err: got %b required 0", resync_err); end
        rst_n = 1'b1;
        model_reset();
        cycle();
        compared++;
        if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_identity();
        logic [255:0] e;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                send_word((r == c) ? 16'h0400 : 16'h0000, (c == 0 && r == 0));
        e = '0;
        for (int i = 0; i < 4; i++) e[16*(4*i+i) +: 16] = 16'h0400;
        compared += 3;
        if (m_valid !== 1'b1) begin mismatched++; $display("FAIL identity_valid: got %b required 1", m_valid); end
        if (m_matrix !== e) begin mismatched++; $display("FAIL identity_matrix: got %h required %h", m_matrix, e); end
        if (m_matrix[95:80] !== 16'h0400) begin mismatched++; $display("FAIL identity_e11: got %h required 0400", m_matrix[95:80]); end
        cycle();
        compared++;
        if (got_q.size() != 1 || got_q[0] !== e) begin mismatched++; $display("FAIL identity_consumed: got %0d matrices required 1", got_q.size()); end
        model_reset();
    endtask

    task automatic test_backpressure();
        logic [255:0] a;
        logic [255:0] b;
        m_ready = 1'b0;
        send_rand_matrix(1'b0);
        send_rand_matrix(1'b0);
        a = exp_q[0];
        b = exp_q[1];
        compared += 3;
        if (s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_s_ready_low: got %b required 0", s_ready); end
        if (m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid: got %b required 1", m_valid); end
        if (m_matrix !== a)   begin mismatched++; $display("FAIL bp_first_held: got %h required %h", m_matrix, a); end
        repeat (3) cycle();
        compared += 2;
        if (m_matrix !== a)   begin mismatched++; $display("FAIL bp_first_stable: got %h required %h", m_matrix, a); end
        if (s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_s_ready_stays_low: got %b required 0", s_ready); end
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        compared += 3;
        if (m_matrix !== b)   begin mismatched++; $display("FAIL bp_second: got %h required %h", m_matrix, b); end
        if (m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_second_valid: got %b required 1", m_valid); end
        if (s_ready !== 1'b1) begin mismatched++; $display("FAIL bp_s_ready_back: got %b required 1", s_ready); end
        m_ready = 1'b1;
        cycle();
        compared += 2;
        if (m_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %b required 0", m_valid); end
        if (got_q.size() != 2) begin mismatched++; $display("FAIL bp_count: got %0d required 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL bp_order[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        model_reset();
    endtask

    task automatic test_resync();
        int r0;
        r0 = resync_cnt;
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) send_word(16'($urandom_range(0, 65535)), (k == 0));
        send_word(16'h0600, 1'b1);
        for (int k = 0; k < 15; k++) send_word(16'($urandom_range(0, 65535)), 1'b0);
        compared += 3;
        if (m_valid !== 1'b1) begin mismatched++; $display("FAIL resync_valid: got %b required 1", m_valid); end
        if (m_matrix[15:0] !== 16'h0600) begin mismatched++; $display("FAIL resync_elem0: got %h required 0600", m_matrix[15:0]); end
        if (resync_cnt - r0 != exp_resync) begin mismatched++; $display("FAIL resync_pulses: got %0d required %0d", resync_cnt - r0, exp_resync); end
        cycle();
        compared++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            mismatched++;
            $display("FAIL resync_matrix: got %0d matrices required %0d", got_q.size(), exp_q.size());
        end
        exp_resync = 0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        int a0;
        int c0;
        m_ready = 1'b1;
        a0 = acc_cnt;
        c0 = cyc_cnt;
        repeat (3) send_rand_matrix(1'b0);
        compared += 2;
        if (acc_cnt - a0 != 48) begin mismatched++; $display("FAIL b2b_accepts: got %0d required 48", acc_cnt - a0); end
        if (cyc_cnt - c0 != 48) begin mismatched++; $display("FAIL b2b_cycles: got %0d required 48", cyc_cnt - c0); end
        cycle();
        compared++;
        if (got_q.size() != 3) begin mismatched++; $display("FAIL b2b_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_order[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        model_reset();
    endtask

    task automatic test_random();
        int r0;
        r0 = resync_cnt;
        exp_resync = 0;
        rand_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 19) == 0) send_word(16'($urandom_range(0, 65535)), 1'b1);
            else send_word(16'($urandom_range(0, 65535)), (mcnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            if ($urandom_range(0, 3) == 0) cycle();
        end
        for (int j = 0; j < 48; j++) send_word(16'($urandom_range(0, 65535)), 1'b0);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        repeat (4) cycle();
        compared += 2;
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        if (resync_cnt - r0 != exp_resync) begin mismatched++; $display("FAIL rand_resync: got %0d required %0d", resync_cnt - r0, exp_resync); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            compared += 2;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand_matrix[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
            if (got_flag_q[i] !== exp_flag_q[i]) begin mismatched++; $display("FAIL rand_flag[%0d]: got %b required %b", i, got_flag_q[i], exp_flag_q[i]); end
        end
        exp_resync = 0;
        model_reset();
    endtask

    task automatic test_range();
        logic [15:0] d;
        m_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 16; k++) begin
                d = 16'($urandom_range(0, 8192));
                if ($urandom_range(0, 1) == 1) d = -d;
                if (m == 0 && k == 6)  d = 16'h2400;
                if (m == 1 && k == 3)  d = 16'h2000;
                if (m == 1 && k == 12) d = 16'hE000;
                if (m == 2 && k == 15) d = 16'h8000;
                send_word(d, (k == 0));
            end
            compared++;
            if (m_range_err !== exp_flag_q[m]) begin mismatched++; $display("FAIL range_flag_m%0d: got %b required %b", m, m_range_err, exp_flag_q[m]); end
        end
        cycle();
        compared++;
        if (got_q.size() != 3) begin mismatched++; $display("FAIL range_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            compared += 2;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL range_matrix[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
            if (got_flag_q[i] !== exp_flag_q[i]) begin mismatched++; $display("FAIL range_delivered_flag[%0d]: got %b required %b", i, got_flag_q[i], exp_flag_q[i]); end
        end
        model_reset();
    endtask

    task automatic test_reset_mid();
        int r0;
        m_ready = 1'b1;
        for (int k = 0; k < 7; k++) send_word(16'($urandom_range(0, 65535)), (k == 0));
        rst_n = 1'b0;
        #2;
        compared += 5;
        if (s_ready !== 1'b0)     begin mismatched++; $display("FAIL mid_rst_s_ready: got %b required 0", s_ready); end
        if (m_valid !== 1'b0)     begin mismatched++; $display("FAIL mid_rst_m_valid: got %b required 0", m_valid); end
        if (m_matrix !== 256'd0)  begin mismatched++; $display("FAIL mid_rst_m_matrix: got %h required 0", m_matrix); end
        if (m_range_err !== 1'b0) begin mismatched++; $display("FAIL mid_rst_range_err: got %b required 0", m_range_err); end
        if (resync_err !== 1'b0)  begin mismatched++; $display("FAIL mid_rst_resync: got %b required 0", resync_err); end
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        r0 = resync_cnt;
        for (int k = 0; k < 16; k++) send_word(16'($urandom_range(0, 65535)), 1'b0);
        cycle();
        compared += 2;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            mismatched++;
            $display("FAIL mid_rst_matrix: got %0d matrices required 1", got_q.size());
        end
        if (resync_cnt != r0) begin mismatched++; $display("FAIL mid_rst_resync_after: got %0d required 0", resync_cnt - r0); end
        model_reset();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_backpressure();
        test_resync();
        test_back_to_back();
        test_range();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream front-end of the QR eigenvalue engine. It accepts a 4x4 Q6.10 matrix as a stream of sixteen 16-bit words over a valid/ready handshake and packs them into the 256-bit matrix bus consumed by the iteration controller as its initial matrix. It is double-buffered: one matrix is held on the output while the next one is collected.

## Interface
Parameters:
- DATA_W, 16: element width, signed Q6.10.
- N, 4: matrix dimension. Fixed at 4; other values are unsupported.
- RANGE_MAX, 16'sd8192: magnitude limit, 8.0 in Q6.10. Used only with the range check.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- s_valid, in, 1: input word valid.
- s_ready, out, 1: loader can accept a word.
- s_first, in, 1: marks the current word as element 0 of a matrix.
- s_data, in, 16: element value.
- m_valid, out, 1: output matrix valid.
- m_ready, in, 1: consumer accepts the matrix.
- m_matrix, out, 256: packed matrix. Element k sits at bits [16k+15:16k]; k = 4*col + row (column-major).
- m_range_err, out, 1: the held matrix contained an out-of-range element.
- resync_err, out, 1: one-cycle pulse when s_first truncates a partial matrix.

## Operation
- Accept rule: a word is accepted on a rising edge where s_valid && s_ready.
- Collect buffer: sixteen 16-bit registers plus a 4-bit index cnt. An accepted word is written to slot cnt, then cnt increments and wraps from 15 to 0.
- Accepted word with s_first=1:
  - It is written to slot 0 and cnt becomes 1.
  - If cnt was nonzero beforehand, the partial matrix is discarded and resync_err pulses for one cycle.
  - s_first=1 with cnt=0 is normal and raises no error.
- s_first=0 with cnt=0 is accepted as element 0. No marker is required.
- State machine:
  - FILL: s_ready=1.
    - On acceptance of word 15: if the output slot is free (m_valid=0, or m_valid && m_ready this cycle), the full buffer plus word 15 is copied into m_matrix at that edge. The state stays FILL.
    - Otherwise the state goes to PEND.
  - PEND: s_ready=0. When m_valid && m_ready, the buffer is copied to the output at that edge and the state returns to FILL.
- Output slot:
  - m_valid is set on copy and cleared on m_valid && m_ready with no simultaneous copy.
  - A simultaneous handshake and copy keeps m_valid=1 and presents the new matrix.
  - m_matrix and m_range_err are stable while m_valid && !m_ready.
- Reset values: s_ready=0 during reset and 1 from the first edge after deassertion. m_valid=0, m_matrix=0, m_range_err=0, resync_err=0, cnt=0, state FILL.
- Reset mid-matrix discards the partial buffer and any held output.

## Timing
- Latency: m_valid rises on the same edge that accepts word 15 when the output slot is free. The matrix is visible in the following cycle.
- Throughput: one word per cycle sustained when m_ready is held high. There is no bubble between matrices.
- In PEND, s_ready drops in the cycle after word 15 is accepted. It rises in the cycle after the output handshake.
- resync_err is high for exactly the one cycle after the offending edge.

## Configuration
- MATRIX_LOADER_RANGE_CHK_EN defined:
  - A per-buffer sticky flag is set when an accepted word has |s_data| > RANGE_MAX. The magnitude is computed in 17 bits, so -32768 is flagged.
  - The flag travels with the matrix into m_range_err.
  - The flag clears on s_first acceptance and when the buffer is copied to the output.
  - The matrix is still delivered; the flag is advisory.
- MATRIX_LOADER_RANGE_CHK_EN undefined: m_range_err is tied 0 and no comparator is built. RANGE_MAX is ignored.

## Structure
- The shared package holds:
  - DATA_W, N, and the element count N*N=16.
  - The state enum {FILL, PEND}.
  - Q6.10 constants ONE=16'sd1024 and the default RANGE_MAX.
  - An index function elem_idx(row,col)=4*col+row. The iteration and QR stages use the same function.
- One sub-module: matrix_loader_buf. It holds the 16-slot collect buffer with its write index and the range flag. The top level holds the FSM and the output slot.

## Test plan
- Identity load: stream 1024,0,0,0,0,1024,… (column-major), m_ready=1. Then m_valid=1 one cycle after word 15, and m_matrix[15:0]=m_matrix[95:80]=m_matrix[175:160]=m_matrix[255:240]=16'h0400 with all other elements 0.
- Backpressure: hold m_ready=0 and stream two matrices. Then s_ready=0 after the second matrix's word 15, and the first matrix is stable. Raise m_ready for one cycle: the second matrix appears next cycle and s_ready returns to 1.
- Resync: send 5 words, then s_first with value 16'h0600, then 15 more words. Then resync_err pulses once, and the output element 0 equals 16'h0600.
- Back-to-back: 3 matrices streamed continuously with m_ready=1. Then 48 accepts in 48 cycles and exactly 3 m_valid handshakes in order.
- Range check (macro defined): an element of 16'sh2400 (9.0) gives m_range_err=1 for that matrix and 0 for the next clean matrix. With the macro undefined, the flag is always 0.
- Reset mid-operation: assert rst_n=0 after 7 words, then send a full matrix. Then outputs are at their reset values during reset, and the delivered matrix contains only post-reset words.
